// File: rtl/pll_reconfig_ctrl.sv
// PLL runtime reconfiguration sequencer.
// Takes a full scan-chain image and shifts it MSB first into the altpll
// scan chain. It then strobes configupdate and waits for scandone. After
// that it pulses areset and waits for lock. Timeouts report via err/err_code.
// Every PLL-facing output comes from a flop, so nothing glitches into the PLL.
module pll_reconfig_ctrl #(
  parameter int SCAN_BITS     = 144,
  parameter int ARESET_CYCLES = 16,
  parameter int DONE_TIMEOUT  = 4096,
  parameter int LOCK_TIMEOUT  = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [SCAN_BITS-1:0] cfg_image,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 pll_scanclk,
  output logic                 pll_scanclkena,
  output logic                 pll_scandata,
  output logic                 pll_configupdate,
  output logic                 pll_areset,
  input  logic                 pll_scandone,
  input  logic                 pll_locked
);

  localparam int T_AD  = (DONE_TIMEOUT > ARESET_CYCLES) ? DONE_TIMEOUT : ARESET_CYCLES;
  localparam int T_MAX = (LOCK_TIMEOUT > T_AD) ? LOCK_TIMEOUT : T_AD;
  localparam int TMR_W = $clog2(T_MAX) + 1;
  localparam int CNT_W = $clog2(SCAN_BITS) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(SCAN_BITS - 1);
  localparam logic [TMR_W-1:0] DONE_LAST   = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ARESET_LAST = TMR_W'(ARESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_UPDATE, S_WAIT_DONE, S_ARESET, S_WAIT_LOCK
  } state_t;

  state_t               state, state_nx;
  logic [SCAN_BITS-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0]     bitcnt, bitcnt_nx;
  logic                 phase, phase_nx;
  logic [TMR_W-1:0]     timer, timer_nx;
  logic                 done_nx, err_nx;
  logic [1:0]           err_code_nx;

  logic scandone_p0, scandone_p1, scandone_p2;
  logic locked_p0, locked_p1;
  logic scandone_rise;

  // Two-flop synchronizers for the PLL status lines, plus one extra stage for scandone edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scandone_p0 <= 1'b0;
      scandone_p1 <= 1'b0;
      scandone_p2 <= 1'b0;
      locked_p0   <= 1'b0;
      locked_p1   <= 1'b0;
    end else begin
      scandone_p0 <= pll_scandone;
      scandone_p1 <= scandone_p0;
      scandone_p2 <= scandone_p1;
      locked_p0   <= pll_locked;
      locked_p1   <= locked_p0;
    end
  end

  assign scandone_rise = scandone_p1 & ~scandone_p2;

  // Next-state logic for the sequencer; one shared timer serves every timed state
  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bitcnt_nx   = bitcnt;
    phase_nx    = phase;
    timer_nx    = timer;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    err_code_nx = err_code;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nx    = S_SHIFT;
          shreg_nx    = cfg_image;
          bitcnt_nx   = '0;
          phase_nx    = 1'b0;
          err_code_nx = 2'b00;
        end
      end
      S_SHIFT: begin
        if (!phase) begin
          phase_nx = 1'b1;
        end else begin
          phase_nx  = 1'b0;
          shreg_nx  = shreg << 1;
          bitcnt_nx = bitcnt + 1'b1;
          if (bitcnt == BIT_LAST) begin
            state_nx = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        state_nx = S_WAIT_DONE;
        timer_nx = '0;
      end
      S_WAIT_DONE: begin
        // A scandone edge on the final timer cycle still counts as success
        if (scandone_rise) begin
          state_nx = S_ARESET;
          timer_nx = '0;
        end else if (timer == DONE_LAST) begin
          state_nx    = S_IDLE;
          err_nx      = 1'b1;
          err_code_nx = 2'b01;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_ARESET: begin
        if (timer == ARESET_LAST) begin
          state_nx = S_WAIT_LOCK;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_p1) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else if (timer == LOCK_LAST) begin
          state_nx    = S_IDLE;
          err_nx      = 1'b1;
          err_code_nx = 2'b10;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register; the PLL-facing outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      shreg            <= '0;
      bitcnt           <= '0;
      phase            <= 1'b0;
      timer            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      err_code         <= 2'b00;
      pll_scanclk      <= 1'b0;
      pll_scanclkena   <= 1'b0;
      pll_scandata     <= 1'b0;
      pll_configupdate <= 1'b0;
      pll_areset       <= 1'b0;
    end else begin
      state            <= state_nx;
      shreg            <= shreg_nx;
      bitcnt           <= bitcnt_nx;
      phase            <= phase_nx;
      timer            <= timer_nx;
      busy             <= (state_nx != S_IDLE);
      done             <= done_nx;
      err              <= err_nx;
      err_code         <= err_code_nx;
      pll_scanclk      <= (state_nx == S_SHIFT) && phase_nx;
      pll_scanclkena   <= (state_nx == S_SHIFT);
      pll_scandata     <= (state_nx == S_SHIFT) && shreg_nx[SCAN_BITS-1];
      pll_configupdate <= (state_nx == S_UPDATE);
      pll_areset       <= (state_nx == S_ARESET);
    end
  end

endmodule
